poci_tx: RTL and testbench

POCI_TX -- requirements
Module: poci_tx

---
 rtl/poci_pkg.sv | 25 ++
 rtl/p2s_shift_register.sv | 44 ++++
 rtl/poci_tx.sv | 173 +++++++++++++++++
 tb/tb_poci_tx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/poci_pkg.sv
// poci_pkg -- shared definitions for the POCI (peripheral-out) serial transmitter.
//
// Contents:
//   POCI_DATA_W      default register/address width
//   ST_*_C           raw 2-bit state encodings, kept so older code and checkers
//                    can compare against a plain logic [1:0] debug bus
//   poci_state_e     transmitter FSM state type (IDLE, ARMED, SHIFT)
//
// Optional feature macro (consumed by poci_tx): POCI_TX_PARITY_EN.

package poci_pkg;

  localparam int POCI_DATA_W = 8;

  localparam logic [1:0] ST_IDLE_C  = 2'd0;
  localparam logic [1:0] ST_ARMED_C = 2'd1;
  localparam logic [1:0] ST_SHIFT_C = 2'd2;

  typedef enum logic [1:0] {
    POCI_IDLE  = ST_IDLE_C,
    POCI_ARMED = ST_ARMED_C,
    POCI_SHIFT = ST_SHIFT_C
  } poci_state_e;

endpackage : poci_pkg

// File: rtl/p2s_shift_register.sv
// p2s_shift_register -- parallel-in, serial-out shift register, MSB first.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset, clears the register
//   load_i   in   capture data_i this edge (wins over shift_i)
//   shift_i  in   shift left by one this edge, zero-filling the LSB
//   data_i   in   W-bit parallel load value
//   msb_o    out  current MSB, i.e. the bit presented on the serial line

module p2s_shift_register #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o
);

  logic [W-1:0] shreg_q;
  logic [W-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      shreg_d = {shreg_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb_o = shreg_q[W-1];

endmodule : p2s_shift_register

// File: rtl/poci_tx.sv
// poci_tx -- SPI POCI read-burst transmitter.
//
// A read burst is armed with a start address, then streams register bytes
// MSB first on serial_out, one bit per sclk rising edge, back-to-back with
// no gap bits. rd_addr always points at the next byte to be loaded; the
// external register mux returns rd_data combinationally from it.
//
// Ports:
//   sclk              in   SPI clock, all state on rising edge
//   rstn              in   asynchronous active-low reset
//   start_addr        in   DATA_W  first register address of a burst
//   start_addr_valid  in   strobe qualifying start_addr
//   tx_en             in   high for the whole frame; low aborts
//   rd_data           in   DATA_W  register contents at rd_addr
//   rd_addr           out  DATA_W  register select to the read mux
//   serial_out        out  POCI data, MSB first; IDLE_LEVEL when not shifting
//   byte_done         out  one-cycle pulse after each byte's final bit
//   busy              out  high in ARMED or SHIFT
//   dbg_state_o       out  raw FSM state (see poci_pkg ST_*_C)
//
// Handshake: start_addr_valid is a one-cycle strobe with no ready; it is
// accepted in IDLE and ARMED and silently dropped in SHIFT. tx_en is a level.
//
// Optional feature: define POCI_TX_PARITY_EN to append one even-parity bit
// after every byte (DATA_W+1 bit periods per byte).

module poci_tx
  import poci_pkg::*;
#(
  parameter int   DATA_W     = POCI_DATA_W,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              sclk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] start_addr,
  input  logic              start_addr_valid,
  input  logic              tx_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rd_addr,
  output logic              serial_out,
  output logic              byte_done,
  output logic              busy,
  output logic [1:0]        dbg_state_o
);

`ifdef POCI_TX_PARITY_EN
  localparam int BITS_PER_BYTE = DATA_W + 1;
`else
  localparam int BITS_PER_BYTE = DATA_W;
`endif
  localparam int              CNT_W    = $clog2(BITS_PER_BYTE);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BITS_PER_BYTE - 1);

  poci_state_e       state_q,     state_d;
  logic [DATA_W-1:0] rd_addr_q,   rd_addr_d;
  logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic              byte_done_q, byte_done_d;

  logic sh_load;
  logic sh_shift;
  logic sh_msb;
  logic line_bit;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = 1'b0;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;

    case (state_q)
      POCI_IDLE: begin
        if (start_addr_valid) begin
          rd_addr_d = start_addr;
          state_d   = POCI_ARMED;
        end
      end

      POCI_ARMED: begin
        // A new address takes priority over tx_en: rd_data still reflects
        // the old address this cycle, so loading now would send stale data.
        if (start_addr_valid) begin
          rd_addr_d = start_addr;
        end else if (tx_en) begin
          sh_load   = 1'b1;
          rd_addr_d = rd_addr_q + DATA_W'(1);
          bit_cnt_d = '0;
          state_d   = POCI_SHIFT;
        end
      end

      POCI_SHIFT: begin
        // Abort beats the byte-boundary reload: no byte_done, address kept.
        if (!tx_en) begin
          bit_cnt_d = '0;
          state_d   = POCI_IDLE;
        end else if (bit_cnt_q == BIT_LAST) begin
          sh_load     = 1'b1;
          rd_addr_d   = rd_addr_q + DATA_W'(1);
          bit_cnt_d   = '0;
          byte_done_d = 1'b1;
        end else begin
          sh_shift  = 1'b1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = POCI_IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= POCI_IDLE;
      rd_addr_q   <= '0;
      bit_cnt_q   <= '0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
    end
  end

  p2s_shift_register #(
    .W (DATA_W)
  ) u_shreg (
    .clk_i   (sclk),
    .rst_ni  (rstn),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .data_i  (rd_data),
    .msb_o   (sh_msb)
  );

`ifdef POCI_TX_PARITY_EN
  // Even parity of the byte being sent, captured alongside the shift-register
  // load and presented during the extra bit period at the end of the byte.
  logic parity_q;
  logic parity_d;

  always_comb begin
    parity_d = parity_q;
    if (sh_load) begin
      parity_d = ^rd_data;
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign line_bit = (bit_cnt_q == BIT_LAST) ? parity_q : sh_msb;
`else
  assign line_bit = sh_msb;
`endif

  assign serial_out  = (state_q == POCI_SHIFT) ? line_bit : IDLE_LEVEL;
  assign rd_addr     = rd_addr_q;
  assign byte_done   = byte_done_q;
  assign busy        = (state_q != POCI_IDLE);
  assign dbg_state_o = state_q;

endmodule : poci_tx

// File: tb/tb_poci_tx.sv
// tb_poci_tx -- bench for poci_tx.
// Register file modelled as an array feeding rd_data combinationally from
// rd_addr. Each burst pushes its per-cycle expected outputs
// {state, busy, byte_done, serial_out, rd_addr} into exp_q, then drives the
// burst and pops one expectation per cycle on the falling edge.

module tb_poci_tx;
  import poci_pkg::*;

  localparam int   W        = 8;
  localparam logic IDLE_LVL = 1'b1;
`ifdef POCI_TX_PARITY_EN
  localparam int BPB = W + 1;
`else
  localparam int BPB = W;
`endif
  localparam int EW = 2 + 1 + 1 + 1 + W;

  // clock / reset
  logic sclk = 1'b0;
  logic rstn;
  always #5 sclk = ~sclk;

  logic [W-1:0] start_addr;
  logic         start_addr_valid;
  logic         tx_en;
  logic [W-1:0] rd_data;
  logic [W-1:0] rd_addr;
  logic         serial_out;
  logic         byte_done;
  logic         busy;
  logic [1:0]   dbg_state;

  logic [W-1:0] regs [256];
  assign rd_data = regs[rd_addr];

  poci_tx #(
    .DATA_W     (W),
    .IDLE_LEVEL (IDLE_LVL)
  ) dut (
    .sclk             (sclk),
    .rstn             (rstn),
    .start_addr       (start_addr),
    .start_addr_valid (start_addr_valid),
    .tx_en            (tx_en),
    .rd_data          (rd_data),
    .rd_addr          (rd_addr),
    .serial_out       (serial_out),
    .byte_done        (byte_done),
    .busy             (busy),
    .dbg_state_o      (dbg_state)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  function automatic logic [EW-1:0] pack(input logic [1:0] st, input logic b,
                                         input logic d, input logic s,
                                         input logic [W-1:0] a);
    return {st, b, d, s, a};
  endfunction

  function automatic logic [EW-1:0] observed();
    return {dbg_state, busy, byte_done, serial_out, rd_addr};
  endfunction

  // Bit p of a byte on the wire: data MSB first, then parity if enabled.
  function automatic logic model_bit(input logic [W-1:0] data, input int p);
    if (p < W) return data[W-1-p];
    return ^data;
  endfunction

  task automatic check(input string tag, input logic [EW-1:0] got,
                       input logic [EW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got st=%0d busy=%b done=%b so=%b addr=%h exp st=%0d busy=%b done=%b so=%b addr=%h",
               tag, got[EW-1 -: 2], got[W+2], got[W+1], got[W], got[W-1:0],
               exp[EW-1 -: 2], exp[W+2], exp[W+1], exp[W], exp[W-1:0]);
    end
  endtask

  task automatic sb_compare(input string tag);
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s scoreboard empty got=%h exp=<none>", tag, observed());
    end else begin
      check(tag, observed(), exp_q.pop_front());
    end
  endtask

  // One burst from addr. nshift = SHIFT cycles observed before tx_en takes
  // effect low; arm_wait = extra ARMED cycles with tx_en low; overwrite =
  // arm at a different address first, then replace it while ARMED;
  // noise = pulse start_addr_valid with a random address mid-SHIFT.
  task automatic run_burst(input logic [W-1:0] addr, input int nshift,
                           input int arm_wait, input bit overwrite,
                           input bit noise);
    logic [W-1:0] first;
    logic [W-1:0] a;
    int           loaded;
    first = overwrite ? (addr ^ 8'h5A) : addr;

    if (overwrite) exp_q.push_back(pack(ST_ARMED_C, 1'b1, 1'b0, IDLE_LVL, first));
    for (int i = 0; i <= arm_wait; i++)
      exp_q.push_back(pack(ST_ARMED_C, 1'b1, 1'b0, IDLE_LVL, addr));
    for (int c = 0; c < nshift; c++) begin
      a = addr + W'(c / BPB);
      exp_q.push_back(pack(ST_SHIFT_C, 1'b1, (c >= BPB) && (c % BPB == 0),
                           model_bit(regs[a], c % BPB), a + 8'd1));
    end
    loaded = (nshift - 1) / BPB + 1;
    exp_q.push_back(pack(ST_IDLE_C, 1'b0, 1'b0, IDLE_LVL, addr + W'(loaded)));

    @(negedge sclk);
    start_addr = first; start_addr_valid = 1'b1; tx_en = 1'b0;
    if (overwrite) begin
      @(negedge sclk); sb_compare("armed_first");
      start_addr = addr; start_addr_valid = 1'b1;
    end
    for (int i = 0; i < arm_wait; i++) begin
      @(negedge sclk); sb_compare("armed_hold");
      start_addr_valid = 1'b0; tx_en = 1'b0;
    end
    @(negedge sclk); sb_compare("armed");
    start_addr_valid = 1'b0; tx_en = 1'b1;
    for (int c = 0; c < nshift; c++) begin
      @(negedge sclk); sb_compare("shift");
      if (noise && c == 2) begin
        start_addr = W'($urandom); start_addr_valid = 1'b1;
      end else begin
        start_addr_valid = 1'b0;
      end
      if (c == nshift - 1) tx_en = 1'b0;
    end
    @(negedge sclk); sb_compare("idle_after");
    start_addr_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; start_addr = '0; start_addr_valid = 1'b0; tx_en = 1'b0;
    for (int i = 0; i < 256; i++) regs[i] = W'($urandom);

    #3; check("reset", observed(), pack(ST_IDLE_C, 1'b0, 1'b0, IDLE_LVL, 8'h00));
    @(negedge sclk); rstn = 1'b1;

    // single byte 0xA5 from 0x05, byte_done once
    regs[8'h05] = 8'hA5;
    run_burst(8'h05, BPB + 1, 0, 1'b0, 1'b0);

    // three-byte burst from 0x10
    regs[8'h10] = 8'h11; regs[8'h11] = 8'h22; regs[8'h12] = 8'h33;
    run_burst(8'h10, 3 * BPB + 1, 1, 1'b0, 1'b0);

    // address wrap FE, FF, 00, 01; abort on last bit of third byte
    run_burst(8'hFE, 3 * BPB, 0, 1'b0, 1'b0);

    // abort after bit 3, then restart with overwrite and ignored mid-SHIFT strobe
    run_burst(8'h20, 4, 2, 1'b0, 1'b0);
    run_burst(8'h21, BPB + 1, 0, 1'b1, 1'b1);

    // abort coinciding with last bit of the byte
    run_burst(8'h80, BPB, 0, 1'b0, 1'b0);

    // parity example byte 0x07
    regs[8'h30] = 8'h07;
    run_burst(8'h30, BPB + 1, 0, 1'b0, 1'b0);

    // asynchronous reset mid-byte
    @(negedge sclk); start_addr = 8'h40; start_addr_valid = 1'b1; tx_en = 1'b0;
    @(negedge sclk); start_addr_valid = 1'b0; tx_en = 1'b1;
    repeat (3) @(negedge sclk);
    check("pre_reset_shift", observed(),
          pack(ST_SHIFT_C, 1'b1, 1'b0, model_bit(regs[8'h40], 2), 8'h41));
    #2 rstn = 1'b0;
    #1 check("reset_async", observed(), pack(ST_IDLE_C, 1'b0, 1'b0, IDLE_LVL, 8'h00));
    @(negedge sclk); rstn = 1'b1;
    @(negedge sclk);
    check("reset_release", observed(), pack(ST_IDLE_C, 1'b0, 1'b0, IDLE_LVL, 8'h00));
    tx_en = 1'b0;
    run_burst(8'h40, 2 * BPB + 1, 0, 1'b0, 1'b0);

    // randomised bursts
    for (int k = 0; k < 6; k++) begin
      run_burst(W'($urandom), $urandom_range(1, 3 * BPB + 1),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_leftover got=%0d entries exp=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_poci_tx
